// File: rtl/retire_reporter_pkg.sv
// -----------------------------------------------------------------------------
// retire_reporter_pkg
// Shared RISC-V constants for the retire reporter: major opcodes used for
// retire classification, the halt-detector state encoding, and a small
// opcode-extraction helper.
// -----------------------------------------------------------------------------
package retire_reporter_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // Halt-pair detector states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEN0  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

  // Retire classification result
  typedef struct packed {
    logic is_branch;
    logic is_store;
    logic is_other;
  } retire_class_t;

  function automatic logic [6:0] get_opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/retire_classify.sv
// -----------------------------------------------------------------------------
// retire_classify
// Combinational decode of a retiring instruction word into branch / store /
// other. Exactly one of the three outputs is high for any input.
//
// Ports:
//   i_inst      in  32  instruction word of the retiring instruction
//   o_is_branch out  1  opcode is BRANCH
//   o_is_store  out  1  opcode is STORE
//   o_is_other  out  1  any other opcode
// -----------------------------------------------------------------------------
module retire_classify
  import retire_reporter_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_is_branch,
  output logic        o_is_store,
  output logic        o_is_other
);

  logic [6:0]    w_opcode;
  retire_class_t w_class;

  assign w_opcode = get_opcode(i_inst);

  always_comb begin
    w_class = '0;
    if (w_opcode == OP_BRANCH) begin
      w_class.is_branch = 1'b1;
    end else if (w_opcode == OP_STORE) begin
      w_class.is_store = 1'b1;
    end else begin
      w_class.is_other = 1'b1;
    end
  end

  assign o_is_branch = w_class.is_branch;
  assign o_is_store  = w_class.is_store;
  assign o_is_other  = w_class.is_other;

endmodule

// File: rtl/retire_reporter.sv
// -----------------------------------------------------------------------------
// retire_reporter
// Observes the retire stream of a RISC-V core, counts retired instructions,
// reports the result value of the last reporting instruction, and detects the
// program-termination pair (HALT_INST0 followed by HALT_INST1, gaps allowed).
// After the pair retires, HALT sticks high and counter/report freeze until
// reset. All outputs are registered (1-cycle latency from the retire edge).
//
// Parameters:
//   HALT_INST0  first word of the halt pair  (addi x1,x0,12)
//   HALT_INST1  second word of the halt pair (jalr x0,0(x1))
//
// Ports:
//   CLK              in   1  clock, rising edge
//   RSTn             in   1  asynchronous active-low reset
//   RETIRE           in   1  one instruction retires this cycle
//   RETIRE_INST      in  32  retiring instruction word
//   RETIRE_RF_WE     in   1  retiring instruction writes the register file
//   RETIRE_RF_WD     in  32  register-file write data
//   RETIRE_BR_TAKEN  in   1  branch outcome
//   RETIRE_ST_ADDR   in  12  store byte address
//   NUM_INST         out 32  retired-instruction count (wraps)
//   OUTPUT_PORT      out 32  result value of the last reporting instruction
//   HALT             out  1  sticky program-termination flag
// -----------------------------------------------------------------------------
module retire_reporter
  import retire_reporter_pkg::*;
#(
  parameter logic [31:0] HALT_INST0 = 32'h00c00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RETIRE,
  input  logic [31:0] RETIRE_INST,
  input  logic        RETIRE_RF_WE,
  input  logic [31:0] RETIRE_RF_WD,
  input  logic        RETIRE_BR_TAKEN,
  input  logic [11:0] RETIRE_ST_ADDR,
  output logic [31:0] NUM_INST,
  output logic [31:0] OUTPUT_PORT,
  output logic        HALT
);

  halt_state_t r_state;
  halt_state_t w_state_next;
  logic [31:0] r_num_inst;
  logic [31:0] w_num_next;
  logic [31:0] r_output;
  logic [31:0] w_output_next;
  logic        r_halt;

  logic w_is_branch;
  logic w_is_store;
  logic w_is_other;
  logic w_accept;

  retire_classify u_classify (
    .i_inst      (RETIRE_INST),
    .o_is_branch (w_is_branch),
    .o_is_store  (w_is_store),
    .o_is_other  (w_is_other)
  );

  // Once halted, retires are ignored entirely.
  assign w_accept = RETIRE && (r_state != ST_HALTED);

  // Halt detector next state
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (RETIRE_INST == HALT_INST0) begin
            w_state_next = ST_SEEN0;
          end
        end
        ST_SEEN0: begin
          // HALT_INST1 is tested first so the pair completes even if the
          // two words happen to be configured equal.
          if (RETIRE_INST == HALT_INST1) begin
            w_state_next = ST_HALTED;
          end else if (RETIRE_INST == HALT_INST0) begin
            w_state_next = ST_SEEN0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Counter and report next values; the retire that completes the halt pair
  // is still counted and reported.
  always_comb begin
    w_num_next    = r_num_inst;
    w_output_next = r_output;
    if (w_accept) begin
      w_num_next = r_num_inst + 32'd1;
      if (w_is_branch) begin
        w_output_next = {31'b0, RETIRE_BR_TAKEN};
      end else if (w_is_store) begin
        w_output_next = {20'b0, RETIRE_ST_ADDR};
      end else if (w_is_other && RETIRE_RF_WE) begin
        w_output_next = RETIRE_RF_WD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_num_inst <= 32'd0;
      r_output   <= 32'd0;
      r_halt     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_num_inst <= w_num_next;
      r_output   <= w_output_next;
      r_halt     <= (w_state_next == ST_HALTED);
    end
  end

  assign NUM_INST    = r_num_inst;
  assign OUTPUT_PORT = r_output;
  assign HALT        = r_halt;

endmodule

// File: tb/tb_retire_reporter.sv
module tb_retire_reporter;

  localparam logic [31:0] H0 = 32'h00c00093;
  localparam logic [31:0] H1 = 32'h00008067;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        RETIRE = 1'b0;
  logic [31:0] RETIRE_INST = 32'd0;
  logic        RETIRE_RF_WE = 1'b0;
  logic [31:0] RETIRE_RF_WD = 32'd0;
  logic        RETIRE_BR_TAKEN = 1'b0;
  logic [11:0] RETIRE_ST_ADDR = 12'd0;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic        HALT;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_num;
  logic [31:0] m_out;
  logic        m_seen0;
  logic        m_halted;

  always #5 CLK = ~CLK;

  retire_reporter #(.HALT_INST0(H0), .HALT_INST1(H1)) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .RETIRE          (RETIRE),
    .RETIRE_INST     (RETIRE_INST),
    .RETIRE_RF_WE    (RETIRE_RF_WE),
    .RETIRE_RF_WD    (RETIRE_RF_WD),
    .RETIRE_BR_TAKEN (RETIRE_BR_TAKEN),
    .RETIRE_ST_ADDR  (RETIRE_ST_ADDR),
    .NUM_INST        (NUM_INST),
    .OUTPUT_PORT     (OUTPUT_PORT),
    .HALT            (HALT)
  );

  task automatic model_reset();
    m_num = 0; m_out = 0; m_seen0 = 0; m_halted = 0;
  endtask

  // Behavioural model of one retire, straight from the reporting rules
  task automatic model_retire(input logic [31:0] inst, input logic we,
                              input logic [31:0] wd, input logic br,
                              input logic [11:0] addr);
    logic [6:0] op;
    if (m_halted) return;
    op = inst[6:0];
    m_num = m_num + 1;
    if (op == 7'b1100011)      m_out = {31'b0, br};
    else if (op == 7'b0100011) m_out = {20'b0, addr};
    else if (we)               m_out = wd;
    if (m_seen0 && inst == H1) m_halted = 1;
    else                       m_seen0 = (inst == H0);
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rise.
  task automatic step(input logic ret, input logic [31:0] inst, input logic we,
                      input logic [31:0] wd, input logic br, input logic [11:0] addr);
    @(negedge CLK);
    RETIRE = ret; RETIRE_INST = inst; RETIRE_RF_WE = we;
    RETIRE_RF_WD = wd; RETIRE_BR_TAKEN = br; RETIRE_ST_ADDR = addr;
    @(posedge CLK);
    #1;
    if (ret) model_retire(inst, we, wd, br, addr);
    RETIRE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 12'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k < 3)      return {r[31:7], 7'b1100011};
    else if (k < 5) return {r[31:7], 7'b0100011};
    else if (k < 8) return r;
    else if (k == 8) return H0;
    else             return H1;
  endfunction

  task automatic test_reset();
    RSTn = 1'b0;
    model_reset();
    #3;
    checks++;
    if (NUM_INST !== 32'd0 || OUTPUT_PORT !== 32'd0 || HALT !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: NUM_INST=%h OUTPUT_PORT=%h HALT=%b required 0/0/0",
               NUM_INST, OUTPUT_PORT, HALT);
    end
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_other_wd();
    step(1'b1, 32'h00100113, 1'b1, 32'h0eec, 1'b0, 12'h0);
    checks++;
    if (NUM_INST !== 32'd1 || OUTPUT_PORT !== 32'h0eec) begin
      errors++;
      $display("FAIL other_wd: NUM_INST=%h OUTPUT_PORT=%h required 1/00000eec", NUM_INST, OUTPUT_PORT);
    end
    $display("other_wd: NUM_INST=%h OUTPUT_PORT=%h", NUM_INST, OUTPUT_PORT);
  endtask

  task automatic test_branch_store();
    logic [31:0] n0;
    n0 = m_num;
    step(1'b1, 32'h00208463, 1'b0, 32'h0, 1'b1, 12'h0);
    checks++;
    if (OUTPUT_PORT !== 32'h1 || NUM_INST !== n0 + 1) begin
      errors++;
      $display("FAIL branch: OUTPUT_PORT=%h NUM_INST=%h required 1/%h", OUTPUT_PORT, NUM_INST, n0 + 1);
    end
    step(1'b1, 32'h00112023, 1'b0, 32'h0, 1'b0, 12'hef0);
    checks++;
    if (OUTPUT_PORT !== 32'h0ef0 || NUM_INST !== n0 + 2) begin
      errors++;
      $display("FAIL store: OUTPUT_PORT=%h NUM_INST=%h required 00000ef0/%h", OUTPUT_PORT, NUM_INST, n0 + 2);
    end
    $display("branch_store: NUM_INST=%h OUTPUT_PORT=%h", NUM_INST, OUTPUT_PORT);
  endtask

  task automatic test_rf_we0();
    logic [31:0] prev;
    logic [31:0] n0;
    prev = OUTPUT_PORT;
    n0 = NUM_INST;
    step(1'b1, 32'h00300193, 1'b0, 32'hdeadbeef, 1'b0, 12'h0);
    checks++;
    if (OUTPUT_PORT !== prev || NUM_INST !== n0 + 1) begin
      errors++;
      $display("FAIL rf_we0: OUTPUT_PORT=%h NUM_INST=%h required %h/%h", OUTPUT_PORT, NUM_INST, prev, n0 + 1);
    end
    $display("rf_we0: NUM_INST=%h OUTPUT_PORT=%h", NUM_INST, OUTPUT_PORT);
  endtask

  task automatic test_halt_gap();
    logic [31:0] n0;
    n0 = NUM_INST;
    step(1'b1, H0, 1'b1, 32'h0c, 1'b0, 12'h0);
    idle(3);
    checks++;
    if (HALT !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: HALT=%b required 0", HALT);
    end
    step(1'b1, H1, 1'b1, 32'h4, 1'b0, 12'h0);
    checks++;
    if (HALT !== 1'b1 || OUTPUT_PORT !== 32'h4 || NUM_INST !== n0 + 2) begin
      errors++;
      $display("FAIL halt_gap: HALT=%b OUTPUT_PORT=%h NUM_INST=%h required 1/00000004/%h",
               HALT, OUTPUT_PORT, NUM_INST, n0 + 2);
    end
    step(1'b1, 32'h00208463, 1'b1, 32'h99, 1'b1, 12'h0);
    checks++;
    if (HALT !== 1'b1 || OUTPUT_PORT !== 32'h4 || NUM_INST !== n0 + 2) begin
      errors++;
      $display("FAIL halt_frozen: HALT=%b OUTPUT_PORT=%h NUM_INST=%h required 1/00000004/%h",
               HALT, OUTPUT_PORT, NUM_INST, n0 + 2);
    end
    $display("halt_gap: HALT=%b NUM_INST=%h OUTPUT_PORT=%h", HALT, NUM_INST, OUTPUT_PORT);
  endtask

  task automatic test_halt_broken();
    step(1'b1, H0, 1'b1, 32'h0c, 1'b0, 12'h0);
    step(1'b1, 32'h00000013, 1'b1, 32'h0, 1'b0, 12'h0);
    step(1'b1, H1, 1'b1, 32'h8, 1'b0, 12'h0);
    checks++;
    if (HALT !== 1'b0) begin
      errors++;
      $display("FAIL halt_broken: HALT=%b required 0", HALT);
    end
    step(1'b1, H0, 1'b1, 32'h0c, 1'b0, 12'h0);
    step(1'b1, H0, 1'b1, 32'h0c, 1'b0, 12'h0);
    step(1'b1, H1, 1'b1, 32'h8, 1'b0, 12'h0);
    checks++;
    if (HALT !== 1'b1 || NUM_INST !== m_num) begin
      errors++;
      $display("FAIL halt_repeat0: HALT=%b NUM_INST=%h required 1/%h", HALT, NUM_INST, m_num);
    end
    $display("halt_broken: HALT=%b NUM_INST=%h", HALT, NUM_INST);
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 32'h44; i++) begin
      w = $urandom();
      step(1'b1, {w[31:7], 7'b0010011}, w[0], $urandom(), 1'b0, 12'h0);
    end
    step(1'b1, H0, 1'b1, 32'h0c, 1'b0, 12'h0);
    step(1'b1, H1, 1'b1, 32'h4, 1'b0, 12'h0);
    checks++;
    if (HALT !== 1'b1 || NUM_INST !== 32'h46) begin
      errors++;
      $display("FAIL pre_async: HALT=%b NUM_INST=%h required 1/00000046", HALT, NUM_INST);
    end
    #2;
    RSTn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (NUM_INST !== 32'd0 || OUTPUT_PORT !== 32'd0 || HALT !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: NUM_INST=%h OUTPUT_PORT=%h HALT=%b required 0/0/0",
               NUM_INST, OUTPUT_PORT, HALT);
    end
    #1;
    RSTn = 1'b1;
    step(1'b1, 32'h00100113, 1'b1, 32'h77, 1'b0, 12'h0);
    checks++;
    if (NUM_INST !== 32'd1 || OUTPUT_PORT !== 32'h77 || HALT !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: NUM_INST=%h OUTPUT_PORT=%h HALT=%b required 1/00000077/0",
               NUM_INST, OUTPUT_PORT, HALT);
    end
    $display("async_reset: NUM_INST=%h OUTPUT_PORT=%h", NUM_INST, OUTPUT_PORT);
  endtask

  task automatic test_random();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      if (m_halted && w[3:0] == 4'd0) do_reset();
      step(w[4] | w[5], rand_inst(), w[6], $urandom(), w[7], w[19:8]);
      checks++;
      if (NUM_INST !== m_num || OUTPUT_PORT !== m_out || HALT !== m_halted) begin
        errors++;
        $display("FAIL random[%0d]: NUM_INST=%h OUTPUT_PORT=%h HALT=%b required %h/%h/%b",
                 i, NUM_INST, OUTPUT_PORT, HALT, m_num, m_out, m_halted);
      end
    end
    $display("random: final NUM_INST=%h OUTPUT_PORT=%h HALT=%b", NUM_INST, OUTPUT_PORT, HALT);
  endtask

  initial begin
    test_reset();
    test_other_wd();
    test_branch_store();
    test_rf_we0();
    test_halt_gap();
    do_reset();
    test_halt_broken();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
